stopwatch_counter: RTL and testbench

- Downstream consumer of the `clock` divider.
- Takes the divider's square-wave 1 Hz, 2 Hz and 4 Hz outputs, edge-detects them in the 100 MHz `clk` domain, and maintains a MM:SS stopwatch value with run, pause, clear and adjust modes.
- Outputs feed the seven-segment display driver, which is scanned by the divider's `faster` output.

---
 rtl/stopwatch_counter_if.sv | 28 ++
 rtl/stopwatch_counter.sv | 103 ++++++++++
 tb/tb_stopwatch_counter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_counter_if.sv
// Stopwatch interface: divider square waves, button pulses and switch levels
// in one direction; the MM:SS value, mode and display helpers in the other.
interface stopwatch_counter_if #(
   parameter int W = 6
);
   logic         one;
   logic         two;
   logic         four;
   logic         pause_p;
   logic         clr_p;
   logic         adj;
   logic         sel;
   logic [W-1:0] minutes;
   logic [W-1:0] seconds;
   logic [1:0]   mode;
   logic         blink;
   logic         sec_tick;

   modport master (
      output one, two, four, pause_p, clr_p, adj, sel,
      input  minutes, seconds, mode, blink, sec_tick
   );

   modport slave (
      input  one, two, four, pause_p, clr_p, adj, sel,
      output minutes, seconds, mode, blink, sec_tick
   );
endinterface

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch fed by the clock divider's 1/2/4 Hz square waves.
// Rising edges of `one` advance the count in RUN; rising edges of `two`
// step the selected field in ADJUST. clr_p zeroes the value, pause_p
// toggles the paused flag in every mode.
module stopwatch_counter #(
   parameter int MAX_SEC = 59,
   parameter int MAX_MIN = 59,
   parameter int W       = 6
) (
   input logic               clk,
   input logic               rst_n,
   stopwatch_counter_if.slave bus
);

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      PAUSED = 2'b01,
      ADJUST = 2'b10
   } mode_t;

   localparam logic [W-1:0] MAX_S = W'(MAX_SEC);
   localparam logic [W-1:0] MAX_M = W'(MAX_MIN);

   logic         one_q;
   logic         two_q;
   logic         t1;
   logic         t2;
   logic         paused;
   logic [W-1:0] minutes;
   logic [W-1:0] seconds;
   logic         blink;
   logic         sec_tick;
   mode_t        mode;

   assign t1   = bus.one & ~one_q;
   assign t2   = bus.two & ~two_q;
   assign mode = bus.adj ? ADJUST : (paused ? PAUSED : RUN);

   assign bus.minutes  = minutes;
   assign bus.seconds  = seconds;
   assign bus.mode     = mode;
   assign bus.blink    = blink;
   assign bus.sec_tick = sec_tick;

   // Edge-detect history; starts high so a wave already high at reset release gives no tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         one_q <= 1'b1;
         two_q <= 1'b1;
      end else begin
         one_q <= bus.one;
         two_q <= bus.two;
      end
   end

   // Pause flag toggles on every pause pulse, independent of clear and of ADJUST
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         paused <= 1'b0;
      end else if (bus.pause_p) begin
         paused <= ~paused;
      end
   end

   // Clear wins over counting; RUN counts MM:SS with carry, ADJUST steps one field without carry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         minutes  <= '0;
         seconds  <= '0;
         sec_tick <= 1'b0;
      end else begin
         sec_tick <= 1'b0;
         if (bus.clr_p) begin
            minutes <= '0;
            seconds <= '0;
         end else if (mode == RUN && t1) begin
            sec_tick <= 1'b1;
            if (seconds < MAX_S) begin
               seconds <= seconds + 1'b1;
            end else begin
               seconds <= '0;
               minutes <= (minutes < MAX_M) ? minutes + 1'b1 : '0;
            end
         end else if (mode == ADJUST && t2) begin
            if (bus.sel) begin
               seconds <= (seconds < MAX_S) ? seconds + 1'b1 : '0;
            end else begin
               minutes <= (minutes < MAX_M) ? minutes + 1'b1 : '0;
            end
         end
      end
   end

   // Blink follows the 4 Hz wave one cycle late while adjusting, otherwise dark
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink <= 1'b0;
      end else begin
         blink <= (mode == ADJUST) & bus.four;
      end
   end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed steps from the test plan followed by
// a randomized run, all checked against a total-seconds reference model.
module tb_stopwatch_counter;

   localparam int W = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   stopwatch_counter_if #(.W(W)) bus ();

   stopwatch_counter #(
      .MAX_SEC(59),
      .MAX_MIN(59),
      .W(W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount   = 0;

   bit curOne, curTwo, curFour, curAdj, curSel;

   int mMin, mSec;
   bit mPaused, prevOne, prevTwo, mTick, mBlink;

   function automatic int expMode();
      return curAdj ? 2 : (mPaused ? 1 : 0);
   endfunction

   task automatic checkValue(input string tag, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      assert (act === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkValue({tag, ".minutes"},  32'(bus.minutes),  32'(mMin));
      checkValue({tag, ".seconds"},  32'(bus.seconds),  32'(mSec));
      checkValue({tag, ".mode"},     32'(bus.mode),     32'(expMode()));
      checkValue({tag, ".blink"},    32'(bus.blink),    32'(mBlink));
      checkValue({tag, ".sec_tick"}, 32'(bus.sec_tick), 32'(mTick));
   endtask

   task automatic modelReset();
      mMin = 0; mSec = 0; mPaused = 1'b0;
      prevOne = 1'b1; prevTwo = 1'b1;
      mTick = 1'b0; mBlink = 1'b0;
   endtask

   // Drive one cycle of inputs (called at posedge+1), advance the model, check after the edge
   task automatic applyStimulus(input bit pauseP, input bit clrP, input string tag);
      bit t1, t2;
      int m, total;
      bus.one = curOne; bus.two = curTwo; bus.four = curFour;
      bus.adj = curAdj; bus.sel = curSel;
      bus.pause_p = pauseP; bus.clr_p = clrP;
      t1 = curOne && !prevOne;
      t2 = curTwo && !prevTwo;
      m  = expMode();
      mTick = 1'b0;
      if (clrP) begin
         mMin = 0; mSec = 0;
      end else if (m == 0 && t1) begin
         total = (mMin * 60 + mSec + 1) % 3600;
         mMin = total / 60; mSec = total % 60; mTick = 1'b1;
      end else if (m == 2 && t2) begin
         if (curSel) mSec = (mSec + 1) % 60;
         else        mMin = (mMin + 1) % 60;
      end
      if (pauseP) mPaused = !mPaused;
      mBlink = (m == 2) && curFour;
      prevOne = curOne; prevTwo = curTwo;
      @(posedge clk); #1;
      checkOutput(tag);
   endtask

   task automatic edgeOne(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         curOne = 1'b0; applyStimulus(1'b0, 1'b0, tag);
         curOne = 1'b1; applyStimulus(1'b0, 1'b0, tag);
      end
   endtask

   task automatic edgeTwo(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         curTwo = 1'b0; applyStimulus(1'b0, 1'b0, tag);
         curTwo = 1'b1; applyStimulus(1'b0, 1'b0, tag);
      end
   endtask

   task automatic driveIdle();
      bus.one = curOne; bus.two = curTwo; bus.four = curFour;
      bus.adj = curAdj; bus.sel = curSel;
      bus.pause_p = 1'b0; bus.clr_p = 1'b0;
   endtask

   initial begin
      curOne = 1'b1; curTwo = 1'b0; curFour = 1'b0; curAdj = 1'b0; curSel = 1'b0;
      driveIdle();
      modelReset();
      @(posedge clk); #1;
      checkOutput("reset");
      rst_n = 1'b1;

      // Held-high wave at release: no tick, then first real edge counts
      applyStimulus(1'b0, 1'b0, "held_one");
      applyStimulus(1'b0, 1'b0, "held_one");
      checkValue("no_tick_at_release", 32'(bus.seconds), 32'd0);
      curOne = 1'b0; applyStimulus(1'b0, 1'b0, "first_edge");
      curOne = 1'b1; applyStimulus(1'b0, 1'b0, "first_edge");
      checkValue("first_sec", 32'(bus.seconds), 32'd1);
      checkValue("first_tick", 32'(bus.sec_tick), 32'd1);
      applyStimulus(1'b0, 1'b0, "tick_drop");
      checkValue("tick_one_cycle", 32'(bus.sec_tick), 32'd0);

      // Seconds carry into minutes
      edgeOne(58, "to_0059");
      checkValue("at_0059_sec", 32'(bus.seconds), 32'd59);
      edgeOne(1, "to_0100");
      checkValue("at_0100_min", 32'(bus.minutes), 32'd1);
      checkValue("at_0100_sec", 32'(bus.seconds), 32'd0);

      // Preload 59:59 through ADJUST, then wrap to 00:00 in RUN
      curAdj = 1'b1; curSel = 1'b0;
      edgeTwo(58, "adj_min59");
      curSel = 1'b1;
      edgeTwo(59, "adj_sec59");
      curAdj = 1'b0;
      applyStimulus(1'b0, 1'b0, "leave_adj");
      curOne = 1'b0; applyStimulus(1'b0, 1'b0, "wrap");
      curOne = 1'b1; applyStimulus(1'b0, 1'b0, "wrap");
      checkValue("wrap_min", 32'(bus.minutes), 32'd0);
      checkValue("wrap_sec", 32'(bus.seconds), 32'd0);
      checkValue("wrap_tick", 32'(bus.sec_tick), 32'd1);

      // Pause holds the count, second pause resumes
      edgeOne(5, "to_0005");
      applyStimulus(1'b1, 1'b0, "pause");
      edgeOne(3, "paused_edges");
      checkValue("paused_mode", 32'(bus.mode), 32'd1);
      checkValue("paused_sec", 32'(bus.seconds), 32'd5);
      applyStimulus(1'b1, 1'b0, "resume");
      edgeOne(1, "resumed_edge");
      checkValue("resumed_mode", 32'(bus.mode), 32'd0);
      checkValue("resumed_sec", 32'(bus.seconds), 32'd6);

      // ADJUST seconds wraps without carry, t1 ignored, blink lags four
      edgeOne(52, "to_0058");
      curAdj = 1'b1; curSel = 1'b1;
      edgeTwo(3, "adj_sec_wrap");
      edgeOne(2, "adj_t1_ignored");
      checkValue("adj_sec", 32'(bus.seconds), 32'd1);
      checkValue("adj_min", 32'(bus.minutes), 32'd0);
      curFour = 1'b1; applyStimulus(1'b0, 1'b0, "blink_on");
      checkValue("blink_on", 32'(bus.blink), 32'd1);
      curFour = 1'b0; applyStimulus(1'b0, 1'b0, "blink_off");
      checkValue("blink_off", 32'(bus.blink), 32'd0);
      curSel = 1'b0;
      edgeTwo(59, "adj_min59b");
      edgeTwo(1, "adj_min_wrap");
      checkValue("adj_min_wrap", 32'(bus.minutes), 32'd0);
      curFour = 1'b1;
      curAdj = 1'b0; applyStimulus(1'b0, 1'b0, "blink_exit");
      checkValue("blink_exit", 32'(bus.blink), 32'd0);
      curFour = 1'b0;

      // Set 12:34, then clear racing a t1 edge, then pause and clear together
      curAdj = 1'b1;
      edgeTwo(12, "set_min12");
      curSel = 1'b1;
      edgeTwo(33, "set_sec34");
      curAdj = 1'b0;
      curOne = 1'b0; applyStimulus(1'b0, 1'b0, "pre_clr");
      checkValue("at_1234_min", 32'(bus.minutes), 32'd12);
      checkValue("at_1234_sec", 32'(bus.seconds), 32'd34);
      curOne = 1'b1; applyStimulus(1'b0, 1'b1, "clr_t1");
      checkValue("clr_t1_sec", 32'(bus.seconds), 32'd0);
      checkValue("clr_t1_tick", 32'(bus.sec_tick), 32'd0);
      checkValue("clr_t1_mode", 32'(bus.mode), 32'd0);
      edgeOne(3, "after_clr");
      applyStimulus(1'b1, 1'b1, "pause_clr");
      checkValue("pause_clr_sec", 32'(bus.seconds), 32'd0);
      checkValue("pause_clr_mode", 32'(bus.mode), 32'd1);

      // 07:42 in ADJUST with paused set, reset asserted mid-operation
      curAdj = 1'b1; curSel = 1'b0;
      edgeTwo(7, "set_min7");
      curSel = 1'b1;
      edgeTwo(42, "set_sec42");
      curFour = 1'b1; applyStimulus(1'b0, 1'b0, "pre_reset");
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("async_reset");
      curAdj = 1'b0; curFour = 1'b0;
      driveIdle();
      #1;
      checkValue("reset_mode_run", 32'(bus.mode), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Randomized run against the model
      for (int i = 0; i < 2000; i++) begin
         bit p, c;
         curOne  = 1'($urandom_range(0, 1));
         curTwo  = 1'($urandom_range(0, 1));
         curFour = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) curAdj = !curAdj;
         if ($urandom_range(0, 15) == 0) curSel = !curSel;
         p = ($urandom_range(0, 29) == 0);
         c = ($urandom_range(0, 199) == 0);
         applyStimulus(p, c, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
